// File: rtl/alu_defs_pkg.sv
// alu_defs: shared definitions for the ALU writeback stage.
//   - CLFZN flag bit positions (C = 4 ... N = 0)
//   - op kind encodings carried alongside each ALU result
//   - the 16 CR16 condition codes
//   - the payload record held in each skid-buffer entry
package alu_defs;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'b00,
    KIND_SCOND = 2'b01,
    KIND_BCOND = 2'b10,
    KIND_CMP   = 2'b11
  } kind_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,
    COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_HI = 4'd4,  COND_LS = 4'd5,
    COND_GT = 4'd6,  COND_LE = 4'd7,
    COND_FS = 4'd8,  COND_FC = 4'd9,
    COND_LO = 4'd10, COND_HS = 4'd11,
    COND_LT = 4'd12, COND_GE = 4'd13,
    COND_UC = 4'd14, COND_NV = 4'd15
  } cond_e;

  // One completed operation as presented to the register file / branch unit.
  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        taken;
  } wb_entry_t;

endpackage

// File: rtl/psr_cond_eval.sv
// psr_cond_eval: combinational CR16 condition-code evaluation.
// Ports:
//   psr_i       [4:0] current PSR flags, CLFZN order
//   cond_i      [3:0] condition code
//   cond_true_o       1 when the condition holds
module psr_cond_eval
  import alu_defs::*;
(
  input  logic [4:0] psr_i,
  input  logic [3:0] cond_i,
  output logic       cond_true_o
);

  logic c, l, f, z, n;

  assign c = psr_i[FLAG_C];
  assign l = psr_i[FLAG_L];
  assign f = psr_i[FLAG_F];
  assign z = psr_i[FLAG_Z];
  assign n = psr_i[FLAG_N];

  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned,
    // which would otherwise infer a latch.
    cond_true_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: cond_true_o = z;
      COND_NE: cond_true_o = !z;
      COND_CS: cond_true_o = c;
      COND_CC: cond_true_o = !c;
      COND_HI: cond_true_o = l;
      COND_LS: cond_true_o = !l;
      COND_GT: cond_true_o = n;
      COND_LE: cond_true_o = !n;
      COND_FS: cond_true_o = f;
      COND_FC: cond_true_o = !f;
      COND_LO: cond_true_o = !l && !z;
      COND_HS: cond_true_o = l || z;
      COND_LT: cond_true_o = !n && !z;
      COND_GE: cond_true_o = n || z;
      COND_UC: cond_true_o = 1'b1;
      COND_NV: cond_true_o = 1'b0;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: pipeline stage after the 16-bit ALU.
// Maintains the PSR, evaluates Scond/Bcond conditions against the PSR as it
// stood before the incoming op, and buffers completed ops in a 2-entry skid
// FIFO feeding the register-file write port and branch unit.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid / in_ready        upstream handshake (in_ready = not full)
//   alu_res, alu_flags         ALU result and CLFZN flags
//   kind, dest, flag_mask,cond op kind, destination, PSR update mask, cond code
//   flush                      synchronous discard of buffer and incoming op
//   out_valid / out_ready      downstream handshake
//   out_we, out_addr, out_data register-file write for the head entry
//   out_taken                  BCOND outcome for the head entry
//   psr                        current PSR
module alu_writeback
  import alu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_res,
  input  logic [4:0]  alu_flags,
  input  logic [1:0]  kind,
  input  logic [3:0]  dest,
  input  logic [4:0]  flag_mask,
  input  logic [3:0]  cond,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [3:0]  out_addr,
  output logic [15:0] out_data,
  output logic        out_taken,
  output logic [4:0]  psr
);

  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [4:0] psr_q, psr_d;
  wb_entry_t  mem_q [DEPTH];
  wb_entry_t  new_entry;
  wb_entry_t  head;
  logic       cond_true;
  logic       push, pop;

  // Evaluated on the registered PSR, i.e. before this op's own flag update.
  psr_cond_eval u_cond (
    .psr_i       (psr_q),
    .cond_i      (cond),
    .cond_true_o (cond_true)
  );

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    new_entry      = '0;
    new_entry.addr = dest;
    case (kind_e'(kind))
      KIND_ALU: begin
        new_entry.we   = 1'b1;
        new_entry.data = alu_res;
      end
      KIND_SCOND: begin
        new_entry.we   = 1'b1;
        new_entry.data = {15'b0, cond_true};
      end
      KIND_BCOND: new_entry.taken = cond_true;
      default:    ;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    psr_d    = psr_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        psr_d    = (psr_q & ~flag_mask) | (alu_flags & flag_mask);
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      psr_q    <= 5'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      psr_q    <= psr_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; stale contents are never
  // visible because every output is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_we    = out_valid && head.we;
  assign out_addr  = out_valid ? head.addr : 4'd0;
  assign out_data  = out_valid ? head.data : 16'd0;
  assign out_taken = out_valid && head.taken;
  assign psr       = psr_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_res;
  logic [4:0]  alu_flags;
  logic [1:0]  kind;
  logic [3:0]  dest;
  logic [4:0]  flag_mask;
  logic [3:0]  cond;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_we;
  logic [3:0]  out_addr;
  logic [15:0] out_data;
  logic        out_taken;
  logic [4:0]  psr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_res   (alu_res),
    .alu_flags (alu_flags),
    .kind      (kind),
    .dest      (dest),
    .flag_mask (flag_mask),
    .cond      (cond),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_taken (out_taken),
    .psr       (psr)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [4:0]  flags;
    logic [4:0]  mask;
    logic [15:0] res;
    logic [3:0]  dest;
    logic        exp_we;
    logic [15:0] exp_data;
    logic        exp_taken;
    logic [4:0]  exp_psr;
  } vec_t;

  localparam logic [1:0] K_ALU = 2'b00, K_SC = 2'b01, K_BC = 2'b10, K_CMP = 2'b11;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] k, input logic [3:0] c, input logic [4:0] fl,
                     input logic [4:0] m, input logic [15:0] r, input logic [3:0] d,
                     input logic we, input logic [15:0] dat, input logic tk,
                     input logic [4:0] p);
    vec_t v;
    v.kind = k; v.cond = c; v.flags = fl; v.mask = m; v.res = r; v.dest = d;
    v.exp_we = we; v.exp_data = dat; v.exp_taken = tk; v.exp_psr = p;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input logic [1:0] k, input logic [3:0] c, input logic [4:0] fl,
                          input logic [4:0] m, input logic [15:0] r, input logic [3:0] d);
    in_valid = 1'b1; kind = k; cond = c; alu_flags = fl; flag_mask = m;
    alu_res = r; dest = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_res = '0; alu_flags = '0; kind = '0;
    dest = '0; flag_mask = '0; cond = '0; flush = 1'b0; out_ready = 1'b1;

    //   kind   cond   flags     mask      res      dest we dat      tk psr
    add(K_ALU, 4'd0,  5'b00010, 5'b11111, 16'h1234, 4'd3, 1, 16'h1234, 0, 5'b00010);
    add(K_CMP, 4'd0,  5'b00010, 5'b11111, 16'h5555, 4'd5, 0, 16'h0000, 0, 5'b00010);
    add(K_BC,  4'd0,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b00010);
    add(K_BC,  4'd1,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b00010);
    add(K_BC,  4'd14, 5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b00010);
    add(K_BC,  4'd15, 5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b00010);
    add(K_SC,  4'd0,  5'b00000, 5'b00000, 16'hFFFF, 4'd7, 1, 16'h0001, 0, 5'b00010);
    add(K_CMP, 4'd0,  5'b00000, 5'b00010, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b00000);
    // SCOND EQ sees old Z=0 even though this op sets Z.
    add(K_SC,  4'd0,  5'b00010, 5'b00010, 16'h0000, 4'd9, 1, 16'h0000, 0, 5'b00010);
    add(K_CMP, 4'd0,  5'b10100, 5'b10100, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b10110);
    add(K_BC,  4'd2,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b10110);
    add(K_BC,  4'd11, 5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b10110);
    add(K_BC,  4'd10, 5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b10110);
    // Partial mask: only L and N updated.
    add(K_ALU, 4'd0,  5'b11111, 5'b01001, 16'hABCD, 4'd15,1, 16'hABCD, 0, 5'b11111);
    add(K_BC,  4'd12, 5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b11111);
    add(K_BC,  4'd13, 5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b11111);
    add(K_BC,  4'd8,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b11111);
    add(K_BC,  4'd7,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b11111);
    add(K_CMP, 4'd0,  5'b00000, 5'b11111, 16'h0000, 4'd2, 0, 16'h0000, 0, 5'b00000);
    add(K_BC,  4'd5,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b00000);
    add(K_BC,  4'd4,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b00000);
    add(K_BC,  4'd6,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 0, 5'b00000);
    add(K_BC,  4'd3,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b00000);
    add(K_BC,  4'd9,  5'b00000, 5'b00000, 16'h0000, 4'd0, 0, 16'h0000, 1, 5'b00000);

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_we",    32'(out_we),    32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_psr",       32'(psr),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Table: one op per cycle with out_ready high; each op is the head after its edge.
    foreach (vecs[i]) begin
      drive_op(vecs[i].kind, vecs[i].cond, vecs[i].flags, vecs[i].mask, vecs[i].res, vecs[i].dest);
      tick();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_we", i),    32'(out_we),    32'(vecs[i].exp_we));
      check($sformatf("v%0d_addr", i),  32'(out_addr),  32'(vecs[i].dest));
      check($sformatf("v%0d_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check($sformatf("v%0d_taken", i), 32'(out_taken), 32'(vecs[i].exp_taken));
      check($sformatf("v%0d_psr", i),   32'(psr),       32'(vecs[i].exp_psr));
    end

    // Drain to empty: all outputs zero.
    in_valid = 1'b0;
    tick();
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_we",    32'(out_we),    32'd0);
    check("empty_addr",  32'(out_addr),  32'd0);
    check("empty_data",  32'(out_data),  32'd0);
    check("empty_taken", 32'(out_taken), 32'd0);

    // Backpressure: three back-to-back ops with out_ready low.
    out_ready = 1'b0;
    drive_op(K_ALU, 4'd0, 5'b0, 5'b0, 16'hA001, 4'd1);
    tick();
    check("bp_ready_after1", 32'(in_ready), 32'd1);
    drive_op(K_ALU, 4'd0, 5'b0, 5'b0, 16'hB002, 4'd2);
    tick();
    check("bp_ready_full", 32'(in_ready), 32'd0);
    check("bp_head_a",     32'(out_data), 32'hA001);
    drive_op(K_ALU, 4'd0, 5'b0, 5'b0, 16'hC003, 4'd3);
    tick();
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_stall_head",  32'(out_data), 32'hA001);
    out_ready = 1'b1;
    tick();
    check("bp_head_b",    32'(out_data), 32'hB002);
    check("bp_addr_b",    32'(out_addr), 32'd2);
    check("bp_ready_rel", 32'(in_ready), 32'd1);
    tick();
    check("bp_head_c", 32'(out_data), 32'hC003);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Flush at count 2 with an incoming op.
    out_ready = 1'b0;
    drive_op(K_ALU, 4'd0, 5'b00100, 5'b11111, 16'h1111, 4'd4);
    tick();
    drive_op(K_ALU, 4'd0, 5'b00000, 5'b00000, 16'h2222, 4'd5);
    tick();
    check("fl_pre_full", 32'(in_ready), 32'd0);
    check("fl_pre_psr",  32'(psr),      32'b00100);
    out_ready = 1'b1;
    drive_op(K_ALU, 4'd0, 5'b11011, 5'b11111, 16'h3333, 4'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    check("fl_psr",   32'(psr),       32'b00100);
    tick();
    check("fl_still_empty", 32'(out_valid), 32'd0);

    // Async reset mid-stream at count 1.
    out_ready = 1'b0;
    drive_op(K_ALU, 4'd0, 5'b11000, 5'b11111, 16'h7777, 4'd8);
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_psr",   32'(psr),       32'b11000);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_we",    32'(out_we),    32'd0);
    check("ar_data",  32'(out_data),  32'd0);
    check("ar_addr",  32'(out_addr),  32'd0);
    check("ar_psr",   32'(psr),       32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("ar_post_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
